// File: rtl/unified_mem_arbiter_if.sv
// Bundles the fetch port, the data port and the memory-macro side of the unified memory arbiter.
// The slave modport is the arbiter's view; the master modport is the core and the memory.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [2:0]        d_funct3;
    logic              d_gnt;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_funct3;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_rdata,
        output if_gnt, if_rdata, if_valid, if_err, d_gnt, d_rdata, d_valid,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_funct3
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_rdata,
        input  if_gnt, if_rdata, if_valid, if_err, d_gnt, d_rdata, d_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_funct3
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the RV32 fetch and load/store ports onto one single-ported memory.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_MAX lost rounds.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    unified_mem_arbiter_if.slave  bus
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STV_W-1:0]    starve_q, starve_d;
    logic                win_data_q, win_data_d;
    logic                if_gnt_q, if_gnt_d, if_valid_q, if_valid_d, if_err_q, if_err_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                d_gnt_q, d_gnt_d, d_valid_q, d_valid_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [2:0]          mem_funct3_q, mem_funct3_d;
    logic                fetch_win_s;

    // Next-state, arbitration and registered-output computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        starve_d     = starve_q;
        win_data_d   = win_data_q;
        if_gnt_d     = 1'b0;
        if_valid_d   = 1'b0;
        if_err_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_gnt_d      = 1'b0;
        d_valid_d    = 1'b0;
        d_rdata_d    = d_rdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_funct3_d = mem_funct3_q;
        fetch_win_s  = bus.if_req && (!bus.d_req || (starve_q == STV_W'(STARVE_MAX)));

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    if (fetch_win_s) begin
                        starve_d = '0;
                        // A misaligned fetch never reaches memory; it is answered with a NOP at once
                        if (bus.if_addr[1:0] != 2'b00) begin
                            if_gnt_d   = 1'b1;
                            if_valid_d = 1'b1;
                            if_err_d   = 1'b1;
                            if_rdata_d = NOP;
                        end else begin
                            if_gnt_d     = 1'b1;
                            mem_en_d     = 1'b1;
                            mem_addr_d   = bus.if_addr;
                            mem_funct3_d = 3'b010;
                            win_data_d   = 1'b0;
                            cnt_d        = CNT_W'(MEM_LAT - 1);
                            state_d      = ACCESS;
                        end
                    end else begin
                        if (!bus.if_req) begin
                            starve_d = '0;
                        end else if (starve_q != STV_W'(STARVE_MAX)) begin
                            starve_d = starve_q + STV_W'(1);
                        end else begin
                            starve_d = starve_q;
                        end
                        d_gnt_d      = 1'b1;
                        mem_en_d     = 1'b1;
                        mem_we_d     = bus.d_we;
                        mem_addr_d   = bus.d_addr;
                        mem_wdata_d  = bus.d_wdata;
                        mem_funct3_d = bus.d_funct3;
                        win_data_d   = 1'b1;
                        cnt_d        = CNT_W'(MEM_LAT - 1);
                        state_d      = ACCESS;
                    end
                end else begin
                    starve_d = '0;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    mem_en_d = 1'b1;
                    mem_we_d = mem_we_q;
                end else begin
                    state_d = IDLE;
                    if (win_data_q) begin
                        d_valid_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            starve_q     <= '0;
            win_data_q   <= 1'b0;
            if_gnt_q     <= 1'b0;
            if_valid_q   <= 1'b0;
            if_err_q     <= 1'b0;
            if_rdata_q   <= '0;
            d_gnt_q      <= 1'b0;
            d_valid_q    <= 1'b0;
            d_rdata_q    <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_funct3_q <= 3'b000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            starve_q     <= starve_d;
            win_data_q   <= win_data_d;
            if_gnt_q     <= if_gnt_d;
            if_valid_q   <= if_valid_d;
            if_err_q     <= if_err_d;
            if_rdata_q   <= if_rdata_d;
            d_gnt_q      <= d_gnt_d;
            d_valid_q    <= d_valid_d;
            d_rdata_q    <= d_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_funct3_q <= mem_funct3_d;
        end
    end

    assign bus.if_gnt     = if_gnt_q;
    assign bus.if_valid   = if_valid_q;
    assign bus.if_err     = if_err_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.d_gnt      = d_gnt_q;
    assign bus.d_valid    = d_valid_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_funct3 = mem_funct3_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) share the stimulus;
// sel picks which one is observed. Random traffic is checked against a grant-schedule model.
module tb_unified_mem_arbiter;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        sel;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, rd_val;
    logic [2:0]  d_f3;
    int          total = 0;
    int          bad = 0;

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(SM))
        u1 (.clk(clk), .reset(reset), .bus(b1));
    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(SM))
        u3 (.clk(clk), .reset(reset), .bus(b3));

    assign b1.if_req = if_req;   assign b3.if_req = if_req;
    assign b1.if_addr = if_addr; assign b3.if_addr = if_addr;
    assign b1.d_req = d_req;     assign b3.d_req = d_req;
    assign b1.d_we = d_we;       assign b3.d_we = d_we;
    assign b1.d_addr = d_addr;   assign b3.d_addr = d_addr;
    assign b1.d_wdata = d_wdata; assign b3.d_wdata = d_wdata;
    assign b1.d_funct3 = d_f3;   assign b3.d_funct3 = d_f3;
    assign b1.mem_rdata = rd_val; assign b3.mem_rdata = rd_val;

    logic        o_ig, o_iv, o_ie, o_dg, o_dv, o_men, o_mwe;
    logic [31:0] o_ird, o_drd, o_maddr, o_mwd;
    logic [2:0]  o_mf3;
    assign o_ig    = sel ? b3.if_gnt     : b1.if_gnt;
    assign o_iv    = sel ? b3.if_valid   : b1.if_valid;
    assign o_ie    = sel ? b3.if_err     : b1.if_err;
    assign o_ird   = sel ? b3.if_rdata   : b1.if_rdata;
    assign o_dg    = sel ? b3.d_gnt      : b1.d_gnt;
    assign o_dv    = sel ? b3.d_valid    : b1.d_valid;
    assign o_drd   = sel ? b3.d_rdata    : b1.d_rdata;
    assign o_men   = sel ? b3.mem_en     : b1.mem_en;
    assign o_mwe   = sel ? b3.mem_we     : b1.mem_we;
    assign o_maddr = sel ? b3.mem_addr   : b1.mem_addr;
    assign o_mwd   = sel ? b3.mem_wdata  : b1.mem_wdata;
    assign o_mf3   = sel ? b3.mem_funct3 : b1.mem_funct3;

    logic any_out1, any_out3;
    assign any_out1 = |{b1.if_gnt, b1.if_valid, b1.if_err, b1.if_rdata, b1.d_gnt, b1.d_valid, b1.d_rdata,
                        b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata, b1.mem_funct3};
    assign any_out3 = |{b3.if_gnt, b3.if_valid, b3.if_err, b3.if_rdata, b3.d_gnt, b3.d_valid, b3.d_rdata,
                        b3.mem_en, b3.mem_we, b3.mem_addr, b3.mem_wdata, b3.mem_funct3};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b0;
        repeat (3) tick();
        total++; if (any_out1 !== 1'b0 || any_out3 !== 1'b0) begin bad++; $display("FAIL reset_outputs got=%b%b want=00", any_out1, any_out3); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fetch;
        sel = 1'b0;
        if_req = 1'b1; if_addr = 32'h10; rd_val = 32'h0050_0093;
        tick();
        total++; if (o_ig !== 1'b1) begin bad++; $display("FAIL fetch_gnt got=%b want=1", o_ig); end
        total++; if (o_men !== 1'b1 || o_mwe !== 1'b0) begin bad++; $display("FAIL fetch_mem_en got=%b%b want=10", o_men, o_mwe); end
        total++; if (o_maddr !== 32'h10 || o_mf3 !== 3'b010) begin bad++; $display("FAIL fetch_mem_addr got=%h/%b want=10/010", o_maddr, o_mf3); end
        if_req = 1'b0;
        tick();
        total++; if (o_iv !== 1'b1 || o_ie !== 1'b0 || o_men !== 1'b0) begin bad++; $display("FAIL fetch_valid got=%b%b%b want=100", o_iv, o_ie, o_men); end
        total++; if (o_ird !== 32'h0050_0093) begin bad++; $display("FAIL fetch_rdata got=%h want=00500093", o_ird); end
    endtask

    task automatic test_load_store;
        sel = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_f3 = 3'b000; rd_val = 32'hFFFF_FF80;
        tick();
        total++; if (o_dg !== 1'b1 || o_men !== 1'b1 || o_mwe !== 1'b0) begin bad++; $display("FAIL load_gnt got=%b%b%b want=110", o_dg, o_men, o_mwe); end
        total++; if (o_mf3 !== 3'b000 || o_maddr !== 32'h100) begin bad++; $display("FAIL load_mem got=%b/%h want=000/100", o_mf3, o_maddr); end
        d_req = 1'b0;
        tick();
        total++; if (o_dv !== 1'b1 || o_drd !== 32'hFFFF_FF80) begin bad++; $display("FAIL load_valid got=%b/%h want=1/ffffff80", o_dv, o_drd); end
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h104; d_wdata = 32'hDEAD_BEEF; d_f3 = 3'b010; rd_val = 32'h1234_5678;
        tick();
        total++; if (o_dg !== 1'b1 || o_mwe !== 1'b1 || o_mwd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_mem got=%b%b/%h want=11/deadbeef", o_dg, o_mwe, o_mwd); end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        total++; if (o_dv !== 1'b1 || o_drd !== 32'hFFFF_FF80) begin bad++; $display("FAIL store_ack got=%b/%h want=1/ffffff80", o_dv, o_drd); end
    endtask

    task automatic test_misaligned;
        sel = 1'b0;
        if_req = 1'b1; if_addr = 32'h12;
        tick();
        total++; if ({o_ig, o_iv, o_ie, o_men} !== 4'b1110) begin bad++; $display("FAIL misalign_flags got=%b want=1110", {o_ig, o_iv, o_ie, o_men}); end
        total++; if (o_ird !== 32'h0000_0013) begin bad++; $display("FAIL misalign_nop got=%h want=00000013", o_ird); end
        if_req = 1'b0;
        tick();
        total++; if ({o_ig, o_iv, o_ie, o_men} !== 4'b0000) begin bad++; $display("FAIL misalign_after got=%b want=0000", {o_ig, o_iv, o_ie, o_men}); end
    endtask

    task automatic test_latency;
        int g1 = -1, g2 = -1, v1 = -1, en = 0;
        logic [31:0] vd = 32'h0;
        sel = 1'b1;
        idle_inputs();
        repeat (6) tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_f3 = 3'b010; rd_val = 32'hA5A5_0001;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (o_dg) begin
                if (g1 < 0) g1 = c;
                else if (g2 < 0) g2 = c;
            end
            if (o_dv && v1 < 0) begin v1 = c; vd = o_drd; end
            if (g1 >= 0 && v1 < 0 && o_men) en++;
            if (g2 >= 0 && v1 >= 0) break;
        end
        idle_inputs();
        total++; if (en !== 3) begin bad++; $display("FAIL lat_mem_en_cycles got=%0d want=3", en); end
        total++; if (v1 - g1 !== 3 || g1 < 0) begin bad++; $display("FAIL lat_gnt_to_valid got=%0d want=3", v1 - g1); end
        total++; if (g2 - g1 !== 4 || g2 < 0) begin bad++; $display("FAIL lat_grant_period got=%0d want=4", g2 - g1); end
        total++; if (vd !== 32'hA5A5_0001) begin bad++; $display("FAIL lat_rdata got=%h want=a5a50001", vd); end
        repeat (6) tick();
    endtask

    task automatic test_contention(input int ngr);
        int got = 0, last = -1;
        logic exp_fetch;
        sel = 1'b1;
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_f3 = 3'b010;
        for (int c = 0; c < 80 && got < ngr; c++) begin
            tick();
            total++; if (o_ig && o_dg) begin bad++; $display("FAIL cont_double_gnt cycle=%0d got=11 want=one", c); end
            if (o_ig || o_dg) begin
                exp_fetch = ((got % 5) == 4);
                total++; if (o_ig !== exp_fetch) begin bad++; $display("FAIL cont_order grant=%0d got_fetch=%b want=%b", got, o_ig, exp_fetch); end
                if (last >= 0) begin
                    total++; if (c - last !== 4) begin bad++; $display("FAIL cont_gap got=%0d want=4", c - last); end
                end
                last = c;
                got++;
            end
        end
        total++; if (got !== ngr) begin bad++; $display("FAIL cont_timeout got=%0d want=%0d", got, ngr); end
        idle_inputs();
        repeat (6) tick();
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        sel = 1'b1;
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        for (int c = 0; c < 40 && seen < 2; c++) begin
            tick();
            if (o_dg) seen++;
        end
        total++; if (seen !== 2) begin bad++; $display("FAIL rmid_setup got=%0d want=2", seen); end
        tick();
        reset = 1'b0;
        idle_inputs();
        tick();
        total++; if (o_men !== 1'b0 || o_dv !== 1'b0) begin bad++; $display("FAIL rmid_drop got=%b%b want=00", o_men, o_dv); end
        total++; if (any_out3 !== 1'b0) begin bad++; $display("FAIL rmid_outputs got=%b want=0", any_out3); end
        reset = 1'b1;
        tick();
        total++; if (o_dv !== 1'b0 || o_men !== 1'b0) begin bad++; $display("FAIL rmid_no_valid got=%b%b want=00", o_dv, o_men); end
        test_contention(5);
    endtask

    task automatic test_random(input logic s, input int lat);
        localparam int N = 200;
        logic [31:0] rd_seq [0:N+7];
        bit          e_ig [0:N+7], e_iv [0:N+7], e_ie [0:N+7], e_dg [0:N+7];
        bit          e_dv [0:N+7], e_men [0:N+7], e_mwe [0:N+7], e_wchk [0:N+7];
        logic [31:0] e_ird [0:N+7], e_drd [0:N+7], e_maddr [0:N+7], e_mwd [0:N+7];
        logic [2:0]  e_mf3 [0:N+7];
        logic [6:0]  of, ef;
        logic [31:0] last_drd = 32'h0;
        int          idle_from = 0, starve = 0;
        bit          if_pend = 0, d_pend = 0, fw;
        for (int i = 0; i < N + 8; i++) begin
            rd_seq[i] = $urandom;
            e_ig[i] = 0; e_iv[i] = 0; e_ie[i] = 0; e_dg[i] = 0;
            e_dv[i] = 0; e_men[i] = 0; e_mwe[i] = 0; e_wchk[i] = 0;
            e_ird[i] = 32'h0; e_drd[i] = 32'h0; e_maddr[i] = 32'h0; e_mwd[i] = 32'h0; e_mf3[i] = 3'b000;
        end
        sel = s;
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            of = {o_ig, o_iv, o_ie, o_dg, o_dv, o_men, o_mwe};
            ef = {e_ig[k], e_iv[k], e_ie[k], e_dg[k], e_dv[k], e_men[k], e_mwe[k]};
            total++; if (of !== ef) begin bad++; $display("FAIL rand_flags lat=%0d k=%0d got=%b want=%b", lat, k, of, ef); end
            if (e_iv[k]) begin
                total++; if (o_ird !== e_ird[k]) begin bad++; $display("FAIL rand_if_rdata k=%0d got=%h want=%h", k, o_ird, e_ird[k]); end
            end
            if (e_dv[k]) begin
                total++; if (o_drd !== e_drd[k]) begin bad++; $display("FAIL rand_d_rdata k=%0d got=%h want=%h", k, o_drd, e_drd[k]); end
            end
            if (e_men[k]) begin
                total++; if (o_maddr !== e_maddr[k] || o_mf3 !== e_mf3[k]) begin bad++; $display("FAIL rand_mem_addr k=%0d got=%h/%b want=%h/%b", k, o_maddr, o_mf3, e_maddr[k], e_mf3[k]); end
            end
            if (e_wchk[k]) begin
                total++; if (o_mwd !== e_mwd[k]) begin bad++; $display("FAIL rand_mem_wdata k=%0d got=%h want=%h", k, o_mwd, e_mwd[k]); end
            end
            if (e_ig[k]) if_pend = 0;
            if (e_dg[k]) d_pend = 0;
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1;
                if ($urandom_range(0, 5) == 0) if_addr = {22'($urandom), 8'($urandom), 2'($urandom_range(1, 3))};
                else if_addr = {22'($urandom), 8'($urandom), 2'b00};
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom; d_f3 = 3'($urandom_range(0, 7));
            end
            if_req = if_pend;
            d_req = d_pend;
            rd_val = rd_seq[k];
            if (k >= idle_from) begin
                if (if_req || d_req) begin
                    fw = if_req && (!d_req || starve == SM);
                    if (fw && if_addr[1:0] != 2'b00) begin
                        starve = 0;
                        e_ig[k+1] = 1; e_iv[k+1] = 1; e_ie[k+1] = 1; e_ird[k+1] = 32'h13;
                        idle_from = k + 1;
                    end else begin
                        if (fw) starve = 0;
                        else starve = if_req ? ((starve < SM) ? starve + 1 : SM) : 0;
                        if (fw) e_ig[k+1] = 1; else e_dg[k+1] = 1;
                        for (int j = 1; j <= lat; j++) begin
                            e_men[k+j] = 1;
                            e_mwe[k+j] = fw ? 1'b0 : d_we;
                            e_maddr[k+j] = fw ? if_addr : d_addr;
                            e_mf3[k+j] = fw ? 3'b010 : d_f3;
                            e_wchk[k+j] = !fw;
                            e_mwd[k+j] = d_wdata;
                        end
                        if (fw) begin
                            e_iv[k+lat+1] = 1; e_ird[k+lat+1] = rd_seq[k+lat];
                        end else begin
                            if (!d_we) last_drd = rd_seq[k+lat];
                            e_dv[k+lat+1] = 1; e_drd[k+lat+1] = last_drd;
                        end
                        idle_from = k + lat + 1;
                    end
                end else begin
                    starve = 0;
                end
            end
            tick();
        end
        idle_inputs();
        repeat (6) tick();
    endtask

    initial begin
        sel = 1'b0; if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_f3 = 3'b000; rd_val = 32'h0;
        idle_inputs();
        test_reset();
        test_fetch();
        test_load_store();
        test_misaligned();
        test_latency();
        test_contention(10);
        test_reset_mid();
        test_random(1'b0, 1);
        test_random(1'b1, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
